mov8_sequencer: RTL and testbench

Control-side initiator for 8-bit register-to-register moves over the shared data bus. On a start request it drives the one-hot select line of the source register, waits for the bus to settle, pulses the one-hot load line of the destination register, then releases in break-before-make order. It sits between the instruction decoder and the register file, the mirror of a register's response to its ld/sel control lines, and drives the front-panel LED lines for every ld/sel it asserts.

---
 rtl/mov8_sequencer.sv | 131 +++++++++++++
 tb/tb_mov8_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mov8_sequencer.sv
// Register-to-register move sequencer: drives one-hot source select, pulses the
// destination load, then releases load before select.
module mov8_sequencer #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LOAD_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] src,
    input  logic [2:0] dst,
    output logic [7:0] sel,
    output logic [7:0] ld,
    output logic [7:0] led_sel,
    output logic [7:0] led_ld,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned LINE_W = 8;

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LOAD_INIT   = CNT_W'(LOAD_W - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SELECT   = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_RELEASE  = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_DONE_ERR = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] src_q, src_d;
    logic [CODE_W-1:0] dst_q, dst_d;
    logic [LINE_W-1:0] sel_q, sel_d;
    logic [LINE_W-1:0] ld_q, ld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Outputs are derived from the next state so they line up with the state they describe.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src;
                    dst_d = dst;
                    if (src != dst) begin
                        state_d = S_SELECT;
                        cnt_d   = SETTLE_INIT;
                    end else begin
                        state_d = S_DONE_ERR;
                    end
                end
            end
            S_SELECT: begin
                if (cnt_q == '0) begin
                    state_d = S_LOAD;
                    cnt_d   = LOAD_INIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q == '0) begin
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RELEASE:  state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            S_DONE_ERR: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase

        sel_d  = '0;
        ld_d   = '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE) || (state_d == S_DONE_ERR);
        err_d  = (state_d == S_DONE_ERR);
        if ((state_d == S_SELECT) || (state_d == S_LOAD) || (state_d == S_RELEASE)) begin
            sel_d = LINE_W'(1) << src_d;
        end
        if (state_d == S_LOAD) begin
            ld_d = LINE_W'(1) << dst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            sel_q   <= '0;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            sel_q   <= sel_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign sel     = sel_q;
    assign ld      = ld_q;
    assign led_sel = sel_q;
    assign led_ld  = ld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mov8_sequencer.sv
// Bench for mov8_sequencer: directed moves, scoreboard of expected moves checked on done,
// plus per-cycle structural checks on the select/load lines.
module tb_mov8_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start;
    logic [2:0] src, dst;
    logic [7:0] sel, ld, led_sel, led_ld;
    logic       busy, done, err;

    logic       reset1, start1;
    logic [2:0] src1, dst1;
    logic [7:0] sel1, ld1, led_sel1, led_ld1;
    logic       busy1, done1, err1;

    mov8_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst),
        .sel(sel), .ld(ld), .led_sel(led_sel), .led_ld(led_ld),
        .busy(busy), .done(done), .err(err)
    );

    mov8_sequencer #(.SETTLE(1), .LOAD_W(1)) dut1 (
        .clk(clk), .reset(reset1), .start(start1), .src(src1), .dst(dst1),
        .sel(sel1), .ld(ld1), .led_sel(led_sel1), .led_ld(led_ld1),
        .busy(busy1), .done(done1), .err(err1)
    );

    typedef struct {
        logic       err;
        logic [7:0] sel;
        logic [7:0] ld;
        int         lat;
    } move_t;

    move_t q[$];
    move_t req;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic e, input logic [7:0] s, input logic [7:0] l, input int lat);
        move_t m;
        m.err = e; m.sel = s; m.ld = l; m.lat = lat;
        q.push_back(m);
    endtask

    // Monitor: per-cycle line checks, accumulates lines seen while busy, scores on done.
    logic [7:0] acc_sel, acc_ld;
    int         bcnt = 0;
    int         ndone = 0;
    logic       done_prev = 1'b0;

    always @(negedge clk) begin
        chk("led_sel_copy", led_sel, sel);
        chk("led_ld_copy", led_ld, ld);
        chk("sel_onehot0", 32'($onehot0(sel)), 1);
        chk("ld_onehot0", 32'($onehot0(ld)), 1);
        chk("ld_without_sel", 32'((ld != 8'h00) && (sel == 8'h00)), 0);
        chk("done_single_cycle", 32'(done_prev && done), 0);
        chk("err_without_done", 32'(err && !done), 0);
        done_prev = done;
        if (busy) begin
            bcnt++;
            acc_sel = acc_sel | sel;
            acc_ld  = acc_ld | ld;
        end
        if (done) begin
            ndone++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                req = q.pop_front();
                chk("sb_err", 32'(err), 32'(req.err));
                chk("sb_sel_lines", 32'(acc_sel), 32'(req.sel));
                chk("sb_ld_lines", 32'(acc_ld), 32'(req.ld));
                chk("sb_busy_cycles", bcnt, req.lat);
            end
        end
        if (!busy || done) begin
            acc_sel = 8'h00;
            acc_ld  = 8'h00;
            bcnt    = 0;
        end
    end

    // Expected lines for cycles T1..T7 of a default-parameter A->B move.
    logic [7:0] t_sel  [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    logic [7:0] t_ld   [7] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
    logic       t_done [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       t_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Expected lines for cycles T1..T5 with SETTLE=1, LOAD_W=1, C->X.
    logic [7:0] f_sel  [5] = '{8'h04, 8'h04, 8'h04, 8'h00, 8'h00};
    logic [7:0] f_ld   [5] = '{8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
    logic       f_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       f_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    int ndone0;

    initial begin
        acc_sel = 8'h00;
        acc_ld  = 8'h00;
        reset  = 1'b1; start  = 1'b0; src  = 3'd0; dst  = 3'd0;
        reset1 = 1'b1; start1 = 1'b0; src1 = 3'd0; dst1 = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_sel", sel, 0);
        chk("rst_ld", ld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst1_sel", sel1, 0);
        reset  = 1'b0;
        reset1 = 1'b0;

        // Default move A -> B, cycle by cycle.
        src = 3'd0; dst = 3'd1; start = 1'b1;
        push(1'b0, 8'h01, 8'h02, 6);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            start = 1'b0;
            chk("ab_sel", sel, t_sel[t]);
            chk("ab_ld", ld, t_ld[t]);
            chk("ab_done", 32'(done), 32'(t_done[t]));
            chk("ab_err", 32'(err), 0);
            chk("ab_busy", 32'(busy), 32'(t_busy[t]));
        end

        // Start held high: Y -> M1 repeats every 7 cycles.
        src = 3'd7; dst = 3'd4; start = 1'b1;
        ndone0 = ndone;
        repeat (3) push(1'b0, 8'h80, 8'h10, 6);
        repeat (21) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("held_done_count", ndone - ndone0, 3);
        chk("held_idle_after", 32'(busy), 0);

        // Rejected request D -> D.
        src = 3'd3; dst = 3'd3; start = 1'b1;
        push(1'b1, 8'h00, 8'h00, 1);
        @(negedge clk);
        start = 1'b0;
        chk("rej_done", 32'(done), 1);
        chk("rej_err", 32'(err), 1);
        chk("rej_busy", 32'(busy), 1);
        chk("rej_sel", sel, 0);
        chk("rej_ld", ld, 0);
        @(negedge clk);
        chk("rej_busy_after", 32'(busy), 0);
        chk("rej_done_after", 32'(done), 0);

        // Reset mid-LOAD aborts without a done, then a fresh move runs.
        src = 3'd1; dst = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_ld_live", ld, 8'h04);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sel", sel, 0);
        chk("abort_ld", ld, 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        reset = 1'b0;
        src = 3'd2; dst = 3'd1; start = 1'b1;
        push(1'b0, 8'h04, 8'h02, 6);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);

        // Inputs disturbed during a move M2 -> A; a start seen in DONE is dropped.
        src = 3'd5; dst = 3'd0; start = 1'b1;
        push(1'b0, 8'h20, 8'h01, 6);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            start = k[0];
            src   = 3'($urandom);
            dst   = 3'($urandom);
            if (k == 3) begin
                chk("hold_sel", sel, 8'h20);
                chk("hold_ld", ld, 8'h01);
            end
            @(negedge clk);
        end
        chk("hold_done", 32'(done), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("drop_start_idle", 32'(busy), 0);
        repeat (10) @(negedge clk);
        chk("no_extra_move", 32'(busy), 0);

        // SETTLE=1, LOAD_W=1 instance, C -> X.
        src1 = 3'd2; dst1 = 3'd6; start1 = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk("fast_sel", sel1, f_sel[t]);
            chk("fast_ld", ld1, f_ld[t]);
            chk("fast_done", 32'(done1), 32'(f_done[t]));
            chk("fast_err", 32'(err1), 0);
            chk("fast_busy", 32'(busy1), 32'(f_busy[t]));
            chk("fast_led_sel", led_sel1, sel1);
            chk("fast_led_ld", led_ld1, ld1);
        end

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
